axi_4_slv_regbank: RTL and testbench
====================================

AXI_4_SLV_REGBANK -- requirements
Module: axi_4_slv_regbank

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, meaning AXI data/register width; legal values are 32 or 64.
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 8, meaning AXI byte-address width.
REQ-003 SHALL have parameter C_NUM_REGS, default 8, meaning implemented registers; legal range is 1..2^(C_ADDR_WIDTH-C_ADDR_LSB).
REQ-004 SHALL have parameter C_RO_MASK, C_NUM_REGS bits, default all 0, meaning bit i=1 makes register i read-only.
REQ-005 SHALL derive C_ADDR_LSB = log2(C_DATA_WIDTH/8) and STRB width C_DATA_WIDTH/8.
REQ-006 S_AXI_ACLK  in  1  sole clock; one clock, all logic on rising edge.
REQ-007 S_AXI_ARESET  in  1  reset, synchronous and active-high.
REQ-008 S_AXI_AWVALID in 1; S_AXI_AWREADY out 1; S_AXI_AWADDR in C_ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored) -- write address channel.
REQ-009 S_AXI_WVALID in 1; S_AXI_WREADY out 1; S_AXI_WDATA in C_DATA_WIDTH; S_AXI_WSTRB in C_DATA_WIDTH/8 -- write data channel.
REQ-010 S_AXI_BVALID out 1; S_AXI_BREADY in 1; S_AXI_BRESP out 2 -- write response.
REQ-011 S_AXI_ARVALID in 1; S_AXI_ARREADY out 1; S_AXI_ARADDR in C_ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored) -- read address.
REQ-012 S_AXI_RVALID out 1; S_AXI_RREADY in 1; S_AXI_RDATA out C_DATA_WIDTH; S_AXI_RRESP out 2 -- read data.
REQ-013 USR_REG_DATA  out  C_NUM_REGS*C_DATA_WIDTH  flattened RW register contents, register i at [i*C_DATA_WIDTH +: C_DATA_WIDTH].
REQ-014 USR_RO_DATA  in  C_NUM_REGS*C_DATA_WIDTH  values returned for read-only registers, same packing.
REQ-015 USR_WR_PULSE  out  C_NUM_REGS  one-cycle strobe per register on successful write commit.

Function
REQ-016 Register index SHALL be ADDR[C_ADDR_WIDTH-1:C_ADDR_LSB]; lower address bits ignored.
REQ-017 AW and W SHALL be accepted independently into one-entry holding buffers; AWREADY = AW buffer empty and BVALID=0; WREADY = W buffer empty and BVALID=0.
REQ-018 Commit SHALL occur on the first edge at which both buffers are full; at that edge both buffers empty, BVALID rises, and (if OKAY) the register updates.
REQ-019 Latency: last of AW/W handshakes at edge k -> register updated and BVALID=1 from edge k+1.
REQ-020 Write SHALL update only bytes with WSTRB bit set; WSTRB=0 SHALL leave the register unchanged but still return OKAY and pulse USR_WR_PULSE.
REQ-021 BRESP SHALL be OKAY (2'b00) for in-range RW index, SLVERR (2'b10) for read-only index, DECERR (2'b11) for index >= C_NUM_REGS; no state change and no USR_WR_PULSE on error.
REQ-022 BVALID/BRESP SHALL hold until BREADY=1; BVALID falls at that edge; new AW/W acceptable from the next cycle.
REQ-023 ARREADY SHALL be 1 when RVALID=0; AR handshake at edge k -> RVALID=1 with RDATA/RRESP valid from edge k.
REQ-024 Read of RW register returns stored value, RO register returns USR_RO_DATA slice sampled at the AR handshake edge, both OKAY; out-of-range returns RDATA=0, DECERR.
REQ-025 RVALID/RDATA/RRESP SHALL hold stable until RREADY=1; RVALID falls at that edge.
REQ-026 Read and write channels SHALL be fully concurrent; read handshake on the same edge as a commit to the same register returns the pre-commit value.
REQ-027 Read-only registers SHALL read back 0 in USR_REG_DATA.

Reset
REQ-028 While S_AXI_ARESET=1 at an edge: all registers 0, buffers empty, AWREADY/WREADY/ARREADY/BVALID/RVALID=0, BRESP/RRESP=00, RDATA=0, USR_WR_PULSE=0.
REQ-029 Readies SHALL be 1 in the first cycle after reset is released.
REQ-030 Reset mid-transaction SHALL discard buffered AW/W and pending B/R responses with no register update.

Verification
REQ-031 AW 0x04 and W 0xDEADBEEF/STRB 0xF same cycle -> BVALID next cycle, BRESP 00, USR_WR_PULSE[1] one cycle, read 0x04 returns 0xDEADBEEF OKAY.
REQ-032 W (0x11223344, STRB 0x5) three cycles before AW 0x08 -> WREADY low after its handshake, commit one edge after AW; reg2 from 0 becomes 0x00220044.
REQ-033 Write to RO index 3 (C_RO_MASK bit3) -> BRESP 10, reg unchanged; read 0x0C returns USR_RO_DATA slice 3 with OKAY; AW to 0x40 with C_NUM_REGS=8 -> BRESP 11, read 0x40 -> RDATA 0, RRESP 11.
REQ-034 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and payload stable, AWREADY/WREADY/ARREADY remain 0 throughout.
REQ-035 Reset asserted with AW buffered and W not yet sent -> after release, W alone causes no commit, no BVALID; all registers read 0.

Source files
------------

// File: rtl/axi_4_slv_regbank.sv
// ---------------------------------------------------------------------------
// axi_4_slv_regbank
//   AXI4-Lite slave register bank. It holds C_NUM_REGS registers, each
//   C_DATA_WIDTH bits wide. The write address and write data channels are
//   accepted independently into one-entry holding buffers. A write commits
//   one edge after both buffers are full, and the write response is held
//   until the master accepts it. Reads are fully concurrent with writes.
//   Registers flagged in C_RO_MASK are read-only. A read of one of them
//   returns the matching slice of USR_RO_DATA, and a write to one gets
//   SLVERR. An index at or beyond C_NUM_REGS gets DECERR.
//
// Ports
//   S_AXI_ACLK          : sole clock, rising edge
//   S_AXI_ARESET        : synchronous, active-high reset
//   S_AXI_AW*           : write address channel (AWPROT ignored)
//   S_AXI_W*            : write data channel with byte strobes
//   S_AXI_B*            : write response channel
//   S_AXI_AR*           : read address channel (ARPROT ignored)
//   S_AXI_R*            : read data channel
//   USR_REG_DATA        : flattened RW register contents (RO slots read 0)
//   USR_RO_DATA         : values returned for read-only registers
//   USR_WR_PULSE        : one-cycle strobe per register on an OKAY commit
// ---------------------------------------------------------------------------
module axi_4_slv_regbank #(
    parameter int                    C_DATA_WIDTH = 32,
    parameter int                    C_ADDR_WIDTH = 8,
    parameter int                    C_NUM_REGS   = 8,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESET,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    output logic [1:0]                         S_AXI_BRESP,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] USR_REG_DATA,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] USR_RO_DATA,
    output logic [C_NUM_REGS-1:0]              USR_WR_PULSE
);

    localparam int C_ADDR_LSB = $clog2(C_DATA_WIDTH / 8);
    localparam int STRB_W     = C_DATA_WIDTH / 8;
    localparam int IDX_W      = C_ADDR_WIDTH - C_ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Merge new write data into the old register value, byte by byte.
    function automatic logic [C_DATA_WIDTH-1:0] apply_strb(
        input logic [C_DATA_WIDTH-1:0] old_val,
        input logic [C_DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]       strb
    );
        logic [C_DATA_WIDTH-1:0] merged;
        merged = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_val[b*8 +: 8];
            end else begin
                merged[b*8 +: 8] = old_val[b*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Register storage and channel state
    logic [C_DATA_WIDTH-1:0] regs_r [C_NUM_REGS];
    logic                    aw_full_r;
    logic [IDX_W-1:0]        aw_idx_r;
    logic                    w_full_r;
    logic [C_DATA_WIDTH-1:0] w_data_r;
    logic [STRB_W-1:0]       w_strb_r;
    logic                    awready_r;
    logic                    wready_r;
    logic                    bvalid_r;
    logic [1:0]              bresp_r;
    logic                    arready_r;
    logic                    rvalid_r;
    logic [C_DATA_WIDTH-1:0] rdata_r;
    logic [1:0]              rresp_r;
    logic [C_NUM_REGS-1:0]   wr_pulse_r;

    // Combinational decode / next-state
    logic                    aw_hs_s;
    logic                    w_hs_s;
    logic                    ar_hs_s;
    logic                    commit_s;
    logic [IDX_W-1:0]        ar_idx_s;
    logic [C_NUM_REGS-1:0]   wr_sel_s;
    logic [C_NUM_REGS-1:0]   rd_sel_s;
    logic [C_NUM_REGS-1:0]   wr_en_s;
    logic [1:0]              wr_resp_s;
    logic [C_DATA_WIDTH-1:0] rd_data_s;
    logic [1:0]              rd_resp_s;
    logic                    aw_full_n_s;
    logic                    w_full_n_s;
    logic                    bvalid_n_s;
    logic                    rvalid_n_s;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_s;
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[C_ADDR_LSB-1:0], S_AXI_ARADDR[C_ADDR_LSB-1:0]};

    assign aw_hs_s  = S_AXI_AWVALID & awready_r;
    assign w_hs_s   = S_AXI_WVALID  & wready_r;
    assign ar_hs_s  = S_AXI_ARVALID & arready_r;
    // Commit uses the registered full flags, so it lands one edge after the last handshake.
    assign commit_s = aw_full_r & w_full_r;
    assign ar_idx_s = S_AXI_ARADDR[C_ADDR_WIDTH-1:C_ADDR_LSB];

    // Decode the buffered write index into a one-hot register select.
    always_comb begin
        wr_sel_s = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (aw_idx_r == IDX_W'(i)) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Classify the pending write and build the per-register write enables.
    always_comb begin
        wr_resp_s = RESP_OKAY;
        if (wr_sel_s == '0) begin
            wr_resp_s = RESP_DECERR;
        end else if ((wr_sel_s & C_RO_MASK) != '0) begin
            wr_resp_s = RESP_SLVERR;
        end else begin
            wr_resp_s = RESP_OKAY;
        end
        // An all-zero select (out of range) or an RO hit yields no enable.
        wr_en_s = wr_sel_s & ~C_RO_MASK & {C_NUM_REGS{commit_s}};
    end

    // Decode the read index and select the returned word from the pre-commit state.
    always_comb begin
        rd_sel_s  = '0;
        rd_data_s = '0;
        rd_resp_s = RESP_DECERR;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (ar_idx_s == IDX_W'(i)) begin
                rd_sel_s[i] = 1'b1;
                rd_resp_s   = RESP_OKAY;
                if (C_RO_MASK[i]) begin
                    rd_data_s = USR_RO_DATA[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                end else begin
                    rd_data_s = regs_r[i];
                end
            end else begin
                rd_sel_s[i] = 1'b0;
            end
        end
    end

    // Channel next-state: buffers fill on handshake and drain together on commit.
    always_comb begin
        aw_full_n_s = aw_full_r;
        w_full_n_s  = w_full_r;
        bvalid_n_s  = bvalid_r;
        rvalid_n_s  = rvalid_r;
        if (commit_s) begin
            aw_full_n_s = 1'b0;
            w_full_n_s  = 1'b0;
            bvalid_n_s  = 1'b1;
        end else begin
            aw_full_n_s = aw_full_r | aw_hs_s;
            w_full_n_s  = w_full_r  | w_hs_s;
            bvalid_n_s  = bvalid_r  & ~S_AXI_BREADY;
        end
        if (ar_hs_s) begin
            rvalid_n_s = 1'b1;
        end else begin
            rvalid_n_s = rvalid_r & ~S_AXI_RREADY;
        end
    end

    // Channel control registers; readies are registered from the next state.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_full_r  <= 1'b0;
            aw_idx_r   <= '0;
            w_full_r   <= 1'b0;
            w_data_r   <= '0;
            w_strb_r   <= '0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= 2'b00;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= '0;
            rresp_r    <= 2'b00;
            wr_pulse_r <= '0;
        end else begin
            aw_full_r  <= aw_full_n_s;
            w_full_r   <= w_full_n_s;
            bvalid_r   <= bvalid_n_s;
            rvalid_r   <= rvalid_n_s;
            awready_r  <= ~aw_full_n_s & ~bvalid_n_s;
            wready_r   <= ~w_full_n_s  & ~bvalid_n_s;
            arready_r  <= ~rvalid_n_s;
            wr_pulse_r <= wr_en_s;
            if (aw_hs_s) begin
                aw_idx_r <= S_AXI_AWADDR[C_ADDR_WIDTH-1:C_ADDR_LSB];
            end
            if (w_hs_s) begin
                w_data_r <= S_AXI_WDATA;
                w_strb_r <= S_AXI_WSTRB;
            end
            if (commit_s) begin
                bresp_r <= wr_resp_s;
            end
            if (ar_hs_s) begin
                rdata_r <= rd_data_s;
                rresp_r <= rd_resp_s;
            end
        end
    end

    // Register array update on an OKAY commit.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_en_s[i]) begin
                    regs_r[i] <= apply_strb(regs_r[i], w_data_r, w_strb_r);
                end
            end
        end
    end

    // Flatten storage for the user side; read-only slots always show zero.
    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_usr_out
        assign USR_REG_DATA[g*C_DATA_WIDTH +: C_DATA_WIDTH] =
            C_RO_MASK[g] ? {C_DATA_WIDTH{1'b0}} : regs_r[g];
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign USR_WR_PULSE  = wr_pulse_r;

endmodule

// File: tb/tb_axi_4_slv_regbank.sv
// ---------------------------------------------------------------------------
// tb_axi_4_slv_regbank
//   Directed self-checking bench for axi_4_slv_regbank with 32-bit data,
//   8-bit addresses, 8 registers and register 3 read-only.
// ---------------------------------------------------------------------------
module tb_axi_4_slv_regbank;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 8;

    logic              clk = 1'b0;
    logic              areset;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [AW-1:0]     awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic [DW-1:0]     wdata, rdata;
    logic [DW/8-1:0]   wstrb;
    logic [1:0]        bresp, rresp;
    logic [NR*DW-1:0]  usr_reg_data, usr_ro_data;
    logic [NR-1:0]     usr_wr_pulse;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    axi_4_slv_regbank #(
        .C_DATA_WIDTH(DW),
        .C_ADDR_WIDTH(AW),
        .C_NUM_REGS  (NR),
        .C_RO_MASK   (8'b0000_1000)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (areset),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .USR_REG_DATA (usr_reg_data),
        .USR_RO_DATA  (usr_ro_data),
        .USR_WR_PULSE (usr_wr_pulse)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue AW and W together, wait for B, capture response, latency and pulse.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, output logic [1:0] resp,
                            output int lat, output logic [NR-1:0] pulse);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            tick();
            lat++;
        end
        resp  = bresp;
        pulse = usr_wr_pulse;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    // Issue AR, wait for R, capture data, response and latency.
    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [1:0] resp, output int lat);
        arvalid = 1'b1; araddr = a;
        tick();
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            tick();
            lat++;
        end
        d    = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick(); tick(); tick();
        checks++; if ({awready, wready, arready} !== 3'b000) begin fails++; $display("FAIL rst_readies: got %b exp 000", {awready, wready, arready}); end
        checks++; if ({bvalid, rvalid} !== 2'b00) begin fails++; $display("FAIL rst_valids: got %b exp 00", {bvalid, rvalid}); end
        checks++; if ({bresp, rresp} !== 4'b0000 || rdata !== 32'h0) begin fails++; $display("FAIL rst_resp_data: got %b/%h exp 0000/0", {bresp, rresp}, rdata); end
        checks++; if (usr_wr_pulse !== 8'h00 || usr_reg_data !== '0) begin fails++; $display("FAIL rst_user: got %h/%h exp 0", usr_wr_pulse, usr_reg_data); end
        areset = 1'b0;
        tick();
        checks++; if ({awready, wready, arready} !== 3'b111) begin fails++; $display("FAIL rst_release_readies: got %b exp 111", {awready, wready, arready}); end
    endtask

    task automatic test_write_basic();
        logic [DW-1:0] d; logic [1:0] r; int lat;
        awvalid = 1'b1; awaddr = 8'h04; wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++; if ({bvalid, awready, wready} !== 3'b000) begin fails++; $display("FAIL wb_buffered: got %b exp 000", {bvalid, awready, wready}); end
        tick();
        checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin fails++; $display("FAIL wb_bvalid: got %b/%b exp 1/00", bvalid, bresp); end
        checks++; if (usr_wr_pulse !== 8'b0000_0010) begin fails++; $display("FAIL wb_pulse: got %b exp 00000010", usr_wr_pulse); end
        checks++; if (usr_reg_data[63:32] !== 32'hDEADBEEF) begin fails++; $display("FAIL wb_reg1: got %h exp deadbeef", usr_reg_data[63:32]); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++; if ({bvalid, usr_wr_pulse} !== 9'b0) begin fails++; $display("FAIL wb_release: got %b exp 0", {bvalid, usr_wr_pulse}); end
        checks++; if ({awready, wready} !== 2'b11) begin fails++; $display("FAIL wb_ready_back: got %b exp 11", {awready, wready}); end
        do_read(8'h04, d, r, lat);
        checks++; if (d !== 32'hDEADBEEF || r !== 2'b00 || lat !== 0) begin fails++; $display("FAIL wb_read: got %h/%b/%0d exp deadbeef/00/0", d, r, lat); end
    endtask

    task automatic test_write_split();
        wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'h5;
        tick();
        wvalid = 1'b0;
        checks++; if ({wready, awready, bvalid} !== 3'b010) begin fails++; $display("FAIL ws_w_only: got %b exp 010", {wready, awready, bvalid}); end
        tick(); tick();
        checks++; if ({bvalid, wready, usr_wr_pulse} !== 10'b0) begin fails++; $display("FAIL ws_waiting: got %b exp 0", {bvalid, wready, usr_wr_pulse}); end
        awvalid = 1'b1; awaddr = 8'h08;
        tick();
        awvalid = 1'b0;
        checks++; if (bvalid !== 1'b0) begin fails++; $display("FAIL ws_aw_edge: got %b exp 0", bvalid); end
        tick();
        checks++; if (bvalid !== 1'b1 || bresp !== 2'b00 || usr_wr_pulse !== 8'b0000_0100) begin fails++; $display("FAIL ws_commit: got %b/%b/%b exp 1/00/00000100", bvalid, bresp, usr_wr_pulse); end
        checks++; if (usr_reg_data[95:64] !== 32'h00220044) begin fails++; $display("FAIL ws_reg2: got %h exp 00220044", usr_reg_data[95:64]); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_strobe();
        logic [1:0] r; int lat; logic [NR-1:0] p;
        do_write(8'h04, 32'hFFFFFFFF, 4'h0, r, lat, p);
        checks++; if (r !== 2'b00 || lat !== 1 || p !== 8'b0000_0010) begin fails++; $display("FAIL strb0_resp: got %b/%0d/%b exp 00/1/00000010", r, lat, p); end
        checks++; if (usr_reg_data[63:32] !== 32'hDEADBEEF) begin fails++; $display("FAIL strb0_reg1: got %h exp deadbeef", usr_reg_data[63:32]); end
        do_write(8'h07, 32'hAABBCCDD, 4'b1000, r, lat, p);
        checks++; if (r !== 2'b00 || usr_reg_data[63:32] !== 32'hAAADBEEF) begin fails++; $display("FAIL strb_msb: got %b/%h exp 00/aaadbeef", r, usr_reg_data[63:32]); end
    endtask

    task automatic test_errors();
        logic [DW-1:0] d; logic [1:0] r; int lat; logic [NR-1:0] p;
        logic [NR*DW-1:0] exp_regs;
        exp_regs = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00220044, 32'hAAADBEEF, 32'h0};
        do_write(8'h0C, 32'h12345678, 4'hF, r, lat, p);
        checks++; if (r !== 2'b10 || lat !== 1 || p !== 8'h00) begin fails++; $display("FAIL ro_write: got %b/%0d/%b exp 10/1/0", r, lat, p); end
        do_read(8'h0C, d, r, lat);
        checks++; if (d !== 32'hCAFEF00D || r !== 2'b00) begin fails++; $display("FAIL ro_read: got %h/%b exp cafef00d/00", d, r); end
        do_write(8'h40, 32'h87654321, 4'hF, r, lat, p);
        checks++; if (r !== 2'b11 || p !== 8'h00) begin fails++; $display("FAIL dec_write: got %b/%b exp 11/0", r, p); end
        do_read(8'h40, d, r, lat);
        checks++; if (d !== 32'h0 || r !== 2'b11) begin fails++; $display("FAIL dec_read: got %h/%b exp 0/11", d, r); end
        do_read(8'h18, d, r, lat);
        checks++; if (d !== 32'h0 || r !== 2'b00) begin fails++; $display("FAIL rw6_read: got %h/%b exp 0/00", d, r); end
        checks++; if (usr_reg_data !== exp_regs) begin fails++; $display("FAIL err_regs: got %h exp %h", usr_reg_data, exp_regs); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d; logic [1:0] r; int lat;
        awvalid = 1'b1; awaddr = 8'h14; wvalid = 1'b1; wdata = 32'h0BADCAFE; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 8'h14;
        tick();
        arvalid = 1'b0;
        checks++; if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h0) begin fails++; $display("FAIL b2b_same_edge: got %b/%b/%h exp 1/1/0", bvalid, rvalid, rdata); end
        checks++; if (usr_wr_pulse !== 8'b0010_0000) begin fails++; $display("FAIL b2b_pulse: got %b exp 00100000", usr_wr_pulse); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({bvalid, bresp, rvalid, rresp} !== 6'b100100 || rdata !== 32'h0) begin fails++; $display("FAIL stall_hold%0d: got %b/%h exp 100100/0", i, {bvalid, bresp, rvalid, rresp}, rdata); end
            checks++; if ({awready, wready, arready} !== 3'b000) begin fails++; $display("FAIL stall_ready%0d: got %b exp 000", i, {awready, wready, arready}); end
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        checks++; if ({bvalid, rvalid} !== 2'b00) begin fails++; $display("FAIL stall_release: got %b exp 00", {bvalid, rvalid}); end
        do_read(8'h14, d, r, lat);
        checks++; if (d !== 32'h0BADCAFE || r !== 2'b00) begin fails++; $display("FAIL b2b_read5: got %h/%b exp 0badcafe/00", d, r); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d; logic [1:0] r; int lat;
        awvalid = 1'b1; awaddr = 8'h04;
        tick();
        awvalid = 1'b0;
        areset = 1'b1;
        tick(); tick();
        areset = 1'b0;
        tick();
        checks++; if ({awready, wready} !== 2'b11 || usr_reg_data !== '0) begin fails++; $display("FAIL rm_cleared: got %b/%h exp 11/0", {awready, wready}, usr_reg_data); end
        wvalid = 1'b1; wdata = 32'h55555555; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bvalid, usr_wr_pulse} !== 9'b0) begin fails++; $display("FAIL rm_no_commit%0d: got %b exp 0", i, {bvalid, usr_wr_pulse}); end
        end
        for (int i = 0; i < NR; i++) begin
            if (i != 3) begin
                do_read(AW'(i * 4), d, r, lat);
                checks++; if (d !== 32'h0 || r !== 2'b00) begin fails++; $display("FAIL rm_read%0d: got %h/%b exp 0/00", i, d, r); end
            end
        end
        checks++; if (usr_reg_data !== '0) begin fails++; $display("FAIL rm_regs: got %h exp 0", usr_reg_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        awvalid = 1'b0; awaddr = '0; awprot = 3'b000;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arprot = 3'b000;
        rready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            usr_ro_data[i*DW +: DW] = 32'h11110000 + 32'(i);
        end
        usr_ro_data[3*DW +: DW] = 32'hCAFEF00D;

        test_reset();
        test_write_basic();
        test_write_split();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
